// File: rtl/stage0_pkg.sv
// Shared types, sizes and boot image for the QLife fetch stage 0.
package stage0_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int RAM_DEPTH = 65536;
    localparam int ROM_DEPTH = 256;
    localparam int ROM_AW    = 8;

    typedef logic [DATA_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Boot image: a short start-up sequence; every unlisted word is zero.
    localparam instr_t BOOT_ROM [ROM_DEPTH] = '{
        0:       32'h0000_0013,
        1:       32'h0000_0013,
        2:       32'h0010_0093,
        3:       32'h0000_0013,
        4:       32'hFCAC_D0A9,
        default: 32'h0000_0000
    };

    // True when the word address falls inside the boot ROM window.
    function automatic logic rom_in_range(input addr_t addr);
        return (addr[ADDR_W-1:ROM_AW] == {(ADDR_W-ROM_AW){1'b0}});
    endfunction

    // Low address bits that index the boot ROM.
    function automatic logic [ROM_AW-1:0] rom_index(input addr_t addr);
        return addr[ROM_AW-1:0];
    endfunction

endpackage

// File: rtl/stage0_fetch_unit_if.sv
// Fetch-stage bus: PC, source select, RAM write port and the two read results.
interface stage0_fetch_unit_if;
    import stage0_pkg::*;

    addr_t  pc;
    logic   execute_from_ram;
    logic   ram_is_write;
    instr_t ram_in;
    instr_t ram_value;
    instr_t instruction_binary;

    modport master (
        output pc,
        output execute_from_ram,
        output ram_is_write,
        output ram_in,
        input  ram_value,
        input  instruction_binary
    );

    modport slave (
        input  pc,
        input  execute_from_ram,
        input  ram_is_write,
        input  ram_in,
        output ram_value,
        output instruction_binary
    );

endinterface

// File: rtl/stage0_boot_rom.sv
// Boot ROM: combinational lookup into the package boot image; out-of-window reads give zero.
module stage0_boot_rom
    import stage0_pkg::*;
(
    input  addr_t  addr,
    output instr_t rdata
);

    instr_t rom_word_s;

    // Look up the boot image inside the ROM window, zero everywhere above it.
    always_comb begin
        rom_word_s = {DATA_W{1'b0}};
        if (rom_in_range(addr)) begin
            rom_word_s = BOOT_ROM[rom_index(addr)];
        end else begin
            rom_word_s = {DATA_W{1'b0}};
        end
    end

    assign rdata = rom_word_s;

endmodule

// File: rtl/stage0_ram32.sv
// Main memory: 64K x 32, synchronous write, asynchronous read.
// Contents survive reset; writes are blocked while reset is asserted.
module stage0_ram32
    import stage0_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  addr_t  addr,
    input  logic   we,
    input  instr_t wdata,
    output instr_t rdata
);

    instr_t mem_r [RAM_DEPTH];

    // Store the write data on the rising edge when enabled and out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read port is a plain combinational lookup, so a write is visible right after its edge.
    assign rdata = mem_r[addr];

endmodule

// File: rtl/stage0_fetch_unit.sv
// Fetch stage 0: selects the instruction word from boot ROM or main RAM at the current PC.
// Both read paths are combinational; reset forces the visible outputs to zero asynchronously.
module stage0_fetch_unit
    import stage0_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    stage0_fetch_unit_if.slave   bus
);

    instr_t ram_word_s;
    instr_t rom_word_s;

    stage0_ram32 u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (bus.pc),
        .we    (bus.ram_is_write),
        .wdata (bus.ram_in),
        .rdata (ram_word_s)
    );

    stage0_boot_rom u_rom (
        .addr  (bus.pc),
        .rdata (rom_word_s)
    );

    // Source mux with reset gating: outputs read zero for as long as rst_n is low.
    always_comb begin
        bus.ram_value          = {DATA_W{1'b0}};
        bus.instruction_binary = {DATA_W{1'b0}};
        if (!rst_n) begin
            bus.ram_value          = {DATA_W{1'b0}};
            bus.instruction_binary = {DATA_W{1'b0}};
        end else begin
            bus.ram_value = ram_word_s;
            if (bus.execute_from_ram) begin
                bus.instruction_binary = ram_word_s;
            end else begin
                bus.instruction_binary = rom_word_s;
            end
        end
    end

endmodule

// File: tb/tb_stage0_fetch_unit.sv
// Directed scoreboard bench for the fetch stage 0 block.
module tb_stage0_fetch_unit;
    import stage0_pkg::*;

    typedef struct {
        string  tag;
        bit     is_rv;
        instr_t exp;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    int   total_checks;
    int   passed_checks;
    sb_entry_t sb_q[$];

    stage0_fetch_unit_if bus ();

    stage0_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic exp_instr(input string tag, input instr_t v);
        sb_entry_t e;
        e.tag = {tag, "/instr"};
        e.is_rv = 1'b0;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_rv(input string tag, input instr_t v);
        sb_entry_t e;
        e.tag = {tag, "/ram_value"};
        e.is_rv = 1'b1;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_both(input string tag, input instr_t vi, input instr_t vr);
        exp_instr(tag, vi);
        exp_rv(tag, vr);
    endtask

    // Let combinational outputs settle, then pop and compare every pending expectation.
    task automatic drain();
        sb_entry_t e;
        instr_t obs;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = e.is_rv ? bus.ram_value : bus.instruction_binary;
            total_checks++;
            assert (obs === e.exp) passed_checks++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic ram_write(input addr_t a, input instr_t d);
        @(negedge clk);
        bus.pc = a;
        bus.ram_in = d;
        bus.ram_is_write = 1'b1;
        @(posedge clk);
        #1;
        bus.ram_is_write = 1'b0;
    endtask

    initial begin
        total_checks = 0;
        passed_checks = 0;
        rst_n = 1'b0;
        bus.pc = 16'h0004;
        bus.execute_from_ram = 1'b0;
        bus.ram_is_write = 1'b0;
        bus.ram_in = 32'h0000_0000;

        // Reset holds both outputs at zero whatever the pc/select.
        exp_both("rst_rom_pc4", 32'h0000_0000, 32'h0000_0000);
        drain();
        bus.pc = 16'hFFFF;
        bus.execute_from_ram = 1'b1;
        exp_both("rst_ram_pcffff", 32'h0000_0000, 32'h0000_0000);
        drain();

        // Leave reset and seed a known word at pc=8.
        @(negedge clk);
        rst_n = 1'b1;
        ram_write(16'h0008, 32'h1111_2222);
        exp_both("seed_pc8", 32'h1111_2222, 32'h1111_2222);
        drain();

        // A write attempted during reset must not land.
        @(negedge clk);
        rst_n = 1'b0;
        bus.pc = 16'h0008;
        bus.ram_in = 32'hBAD0_BAD0;
        bus.ram_is_write = 1'b1;
        @(posedge clk);
        exp_both("rst_write_outputs", 32'h0000_0000, 32'h0000_0000);
        drain();
        bus.ram_is_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_both("rst_write_blocked", 32'h1111_2222, 32'h1111_2222);
        drain();

        // Boot ROM fetch.
        bus.pc = 16'h0004;
        bus.execute_from_ram = 1'b0;
        exp_instr("rom_pc4", 32'hFCAC_D0A9);
        drain();

        // Same-cycle write/read: old word until the edge, new word after it.
        ram_write(16'h0004, 32'h0A0A_0A0A);
        @(negedge clk);
        bus.pc = 16'h0004;
        bus.ram_in = 32'hE5F8_4AB1;
        bus.ram_is_write = 1'b1;
        exp_rv("pre_edge_old", 32'h0A0A_0A0A);
        drain();
        @(posedge clk);
        #1;
        bus.ram_is_write = 1'b0;
        bus.execute_from_ram = 1'b1;
        exp_both("ram_pc4", 32'hE5F8_4AB1, 32'hE5F8_4AB1);
        drain();
        bus.execute_from_ram = 1'b0;
        exp_instr("sel_back_rom", 32'hFCAC_D0A9);
        drain();

        // Address extremes, no aliasing.
        ram_write(16'hFFFF, 32'h1234_5678);
        ram_write(16'h0000, 32'hCAFE_BABE);
        bus.execute_from_ram = 1'b1;
        bus.pc = 16'hFFFF;
        exp_both("ram_pcffff", 32'h1234_5678, 32'h1234_5678);
        drain();
        bus.pc = 16'h0000;
        exp_both("ram_pc0", 32'hCAFE_BABE, 32'hCAFE_BABE);
        drain();
        bus.pc = 16'h0004;
        exp_rv("pc4_untouched", 32'hE5F8_4AB1);
        drain();

        // ROM window edges.
        bus.execute_from_ram = 1'b0;
        bus.pc = 16'h0100;
        exp_instr("rom_pc100", 32'h0000_0000);
        drain();
        bus.pc = 16'h00FF;
        exp_instr("rom_pcff", 32'h0000_0000);
        drain();

        // Write enable low: clocking the pc must not change the word.
        @(negedge clk);
        bus.pc = 16'h0004;
        bus.ram_in = 32'hDEAD_BEEF;
        bus.ram_is_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.execute_from_ram = 1'b1;
        exp_both("we_low_keep", 32'hE5F8_4AB1, 32'hE5F8_4AB1);
        drain();

        // Asynchronous reset between edges while fetching from RAM.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_both("async_rst", 32'h0000_0000, 32'h0000_0000);
        drain();
        rst_n = 1'b1;
        exp_both("async_release", 32'hE5F8_4AB1, 32'hE5F8_4AB1);
        drain();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
